seg_digit_decoder: RTL and testbench
====================================

// Module: seg_digit_decoder
// PURPOSE
//  Downstream stage of the pixel_clk/pixel_controller scan pair. Takes the scan
//  select seq_sel[2:0] and anode vector a[7:0] produced by the controller, plus
//  a 32-bit display word (8 hex nibbles). Drives registered, anode-aligned
//  7-segment cathodes and decimal point.
//  A shadow/active double buffer commits new words only at a frame boundary,
//  so a scan never shows a half-updated word.
// PARAMETERS
//  SEL_W    3    scan select width; digit count = 2**SEL_W (8)
//  SEG_OFF  7'h7F  cathode pattern for a blank digit (all segments off)
// PORTS
//  clk       in   1   system clock; all logic on rising edge
//  reset     in   1   synchronous, active-low reset (asserted when 0)
//  data_in   in   32  display word; nibble k = data_in[4k+3:4k] -> digit k
//  dp_in     in   8   decimal points, active-high; bit k -> digit k
//  load      in   1   1-cycle strobe: capture data_in/dp_in into shadow
//  seq_sel   in   3   current digit index from the scan controller
//  a_in      in   8   active-low anodes from the scan controller
//  an_out    out  8   active-low anodes, delayed to align with seg/dp
//  seg       out  7   active-low cathodes {g,f,e,d,c,b,a}
//  dp        out  1   active-low decimal point
//  pending   out  1   high while shadow holds an uncommitted word
//  load_ack  out  1   1-cycle pulse on the cycle a word is committed to active
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge): shadow=0, active=0, dp regs=0, pending=0,
//    load_ack=0, an_out=8'hFF, seg=SEG_OFF, dp=1, sel pipeline=0, prev_sel=0.
//  - seq_sel and a_in are synchronous to clk and change at most once per 2 clk.
//  - Pipeline: S1 registers seq_sel/a_in. S2 decodes from S1 plus active regs
//    and registers an_out/seg/dp. Output latency = 2 clk from input change.
//    an_out always equals a_in delayed by exactly 2 clk.
//  - Frame boundary (fb): S1 sel == 0 and previous S1 sel == 7. It is one clk wide.
//  - Commit rules, evaluated each clk:
//      load & !fb : shadow<=inputs, pending<=1.
//      fb & pending & !load : active<=shadow, pending<=0, load_ack<=1.
//      fb & load  : active<=inputs directly (bypass), shadow<=inputs,
//                   pending<=0, load_ack<=1.
//      otherwise  : hold; load_ack<=0.
//  - Repeated loads before fb overwrite the shadow: last write wins, one ack only.
//  - Decode (hex -> seg, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//    8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E. dp = ~dp_active[S1 sel].
//  - Reset mid-frame blanks outputs on the next clk and drops any pending word.
//    The first fb after reset release commits nothing unless a load occurred.
// CONFIGURATION
//  LZ_BLANK_EN defined: a blank_mask[7:0] register is written on every commit.
//    Digits above the most-significant nonzero nibble get mask=1 and output
//    seg=SEG_OFF with their dp still honoured.
//    Digit 0 is never blanked, so word 0 shows a single "0".
//    blank_mask resets to 8'hFE.
//  LZ_BLANK_EN undefined: no mask register; all 8 digits are always decoded.
// TESTING
//  1 Hold reset=0 for 3 clk -> an_out=FF, seg=7F, dp=1, pending=0, load_ack=0.
//  2 Load 32'h1234ABCD at sel=3 -> pending=1 and output unchanged until wrap.
//    At fb: load_ack pulses and pending=0. 2 clk after sel=0: seg=21 ("d"),
//    an_out=FE. At sel=7: seg=79 ("1").
//  3 Load 32'h11111111, then 32'h22222222 before fb -> one load_ack; every
//    digit shows 24.
//  4 Load 32'h55555555 with load coincident with fb -> committed on the same
//    edge, load_ack=1, pending=0, digit 0 shows 12 in the same frame.
//  5 With LZ_BLANK_EN, load 32'h00000042 with dp_in=8'h80 -> digit0=24,
//    digit1=19, digits 2-6 seg=7F dp=1, digit 7 seg=7F dp=0.
//    Load 0 -> only digit 0 shows 40.
//  6 Assert reset mid-frame with pending=1 -> next clk outputs blank and
//    pending=0. After release, the first fb gives no load_ack.

Source files
------------

// File: rtl/seg_digit_decoder.sv
// Hex-to-7-segment scan stage with frame-aligned shadow/active word buffer.
// Optional LZ_BLANK_EN macro enables leading-zero blanking.
module seg_digit_decoder #(
  parameter int         SEL_W   = 3,
  parameter logic [6:0] SEG_OFF = 7'h7F
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4*(2**SEL_W)-1:0] data_in,
  input  logic [(2**SEL_W)-1:0]   dp_in,
  input  logic                 load,
  input  logic [SEL_W-1:0]     seq_sel,
  input  logic [(2**SEL_W)-1:0]   a_in,
  output logic [(2**SEL_W)-1:0]   an_out,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic                 pending,
  output logic                 load_ack
);

  localparam int N = 2**SEL_W;

  logic [SEL_W-1:0] sel_q, prev_q;
  logic [N-1:0]     a_q;
  logic [4*N-1:0]   shadow_q, shadow_d;
  logic [N-1:0]     sdp_q, sdp_d;
  logic [4*N-1:0]   act_q, act_d;
  logic [N-1:0]     adp_q, adp_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic [N-1:0]     an_q;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             fb, commit, blank;
  logic [3:0]       nib;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    fb     = (sel_q == '0) && (prev_q == '1);
    commit = fb && (load || pend_q);

    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    if (load) begin
      shadow_d = data_in;
      sdp_d    = dp_in;
    end

    act_d = act_q;
    adp_d = adp_q;
    if (fb && load) begin
      act_d = data_in;
      adp_d = dp_in;
    end else if (fb && pend_q) begin
      act_d = shadow_q;
      adp_d = sdp_q;
    end

    pend_d = pend_q;
    if (load && !fb) pend_d = 1'b1;
    else if (fb)     pend_d = 1'b0;

    ack_d = commit;
  end

  // Decode looks at the word being committed this edge, so a freshly
  // committed frame is visible from its very first digit.
  assign nib = act_d[{sel_q, 2'b00} +: 4];

`ifdef LZ_BLANK_EN
  logic [N-1:0] mask_q, mask_d, mask_nx;

  always_comb begin
    logic hz;
    hz     = 1'b1;
    mask_d = '0;
    for (int k = N-1; k >= 1; k--) begin
      hz        = hz && (act_d[4*k +: 4] == 4'h0);
      mask_d[k] = hz;
    end
    mask_nx = commit ? mask_d : mask_q;
    blank   = mask_nx[sel_q];
  end

  always_ff @(posedge clk) begin
    if (!reset)      mask_q <= {{(N-1){1'b1}}, 1'b0};
    else if (commit) mask_q <= mask_d;
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_d = blank ? SEG_OFF : hex7(nib);
    dp_d  = ~adp_d[sel_q];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q    <= '0;
      prev_q   <= '0;
      a_q      <= '1;
      shadow_q <= '0;
      sdp_q    <= '0;
      act_q    <= '0;
      adp_q    <= '0;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      an_q     <= '1;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      sel_q    <= seq_sel;
      prev_q   <= sel_q;
      a_q      <= a_in;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      act_q    <= act_d;
      adp_q    <= adp_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      an_q     <= a_q;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an_out   = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign pending  = pend_q;
  assign load_ack = ack_q;

endmodule

// File: tb/tb_seg_digit_decoder.sv
// Randomized bench for seg_digit_decoder against a word-level display model.
// Build with +define+LZ_BLANK_EN to check leading-zero blanking.
module tb_seg_digit_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        load;
  logic [2:0]  seq_sel;
  logic [7:0]  a_in;
  logic [7:0]  an_out;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;
  logic        load_ack;

  seg_digit_decoder dut (
    .clk      (clk),
    .reset    (rst),
    .data_in  (data_in),
    .dp_in    (dp_in),
    .load     (load),
    .seq_sel  (seq_sel),
    .a_in     (a_in),
    .an_out   (an_out),
    .seg      (seg),
    .dp       (dp),
    .pending  (pending),
    .load_ack (load_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

  // Display model: what word is on screen and what is waiting to go up.
  logic [31:0] m_word, m_shadow;
  logic [7:0]  m_wdp, m_sdp;
  logic        m_pend;
  int          h1, h2;
  logic [7:0]  ha1;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_pend, e_ack;

  int scan_sel = 0;
  int scan_hold = 2;

  function automatic bit blanked(input logic [31:0] w, input int d);
`ifdef LZ_BLANK_EN
    int msd = 0;
    for (int k = 0; k < 8; k++)
      if (((w >> (4*k)) & 32'hF) != 0) msd = k;
    return d > msd;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit fb_next();
    return h1 == 0 && h2 == 7;
  endfunction

  task automatic scan_drive();
    seq_sel = 3'(scan_sel);
    a_in    = ~(8'h01 << scan_sel);
  endtask

  task automatic scan_advance();
    scan_hold--;
    if (scan_hold == 0) begin
      scan_sel  = (scan_sel + 1) % 8;
      scan_hold = $urandom_range(2, 3);
    end
  endtask

  task automatic step();
    bit fb;
    int d;
    scan_drive();
    fb = fb_next();
    @(posedge clk);
    if (!rst) begin
      m_word = 0; m_shadow = 0; m_wdp = 0; m_sdp = 0; m_pend = 0;
      h1 = 0; h2 = 0; ha1 = 8'hFF;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_pend = 0; e_ack = 0;
    end else begin
      e_ack = fb && (load || m_pend);
      if (fb && load) begin
        m_word = data_in; m_wdp = dp_in;
      end else if (fb && m_pend) begin
        m_word = m_shadow; m_wdp = m_sdp;
      end
      if (load) begin
        m_shadow = data_in; m_sdp = dp_in;
      end
      if (fb)        m_pend = 0;
      else if (load) m_pend = 1;
      e_pend = m_pend;
      d      = h1;
      e_an   = ha1;
      e_seg  = blanked(m_word, d) ? 7'h7F
                                  : hex_tab[(m_word >> (4*d)) & 32'hF];
      e_dp   = ~m_wdp[d];
      h2  = h1;
      h1  = int'(seq_sel);
      ha1 = a_in;
    end
    @(negedge clk);
    chk("an_out", 32'(an_out), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("pending", 32'(pending), 32'(e_pend));
    chk("load_ack", 32'(load_ack), 32'(e_ack));
    load = 1'b0;
    scan_advance();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [31:0] w, input logic [7:0] p);
    data_in = w; dp_in = p; load = 1'b1;
    step();
  endtask

  task automatic wait_sel(input int s);
    for (int i = 0; i < 64 && scan_sel != s; i++) step();
  endtask

  task automatic wait_fb();
    for (int i = 0; i < 64 && !fb_next(); i++) step();
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
    h1 = 0; h2 = 0; ha1 = 8'hFF;
    scan_drive();
    @(negedge clk);
    run(3);
    rst = 1'b1;
    run(4);

    wait_sel(3);
    do_load(32'h1234ABCD, 8'h00);
    run(40);

    wait_sel(2);
    do_load(32'h11111111, 8'h0F);
    step();
    do_load(32'h22222222, 8'hF0);
    run(40);

    wait_fb();
    do_load(32'h55555555, 8'h01);
    run(24);

    wait_sel(4);
    do_load(32'h00000042, 8'h80);
    run(40);
    wait_sel(4);
    do_load(32'h00000000, 8'h00);
    run(40);

    wait_sel(4);
    do_load(32'hCAFE0001, 8'h11);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    run(40);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) rst = 1'b0;
      else rst = 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        data_in = $urandom >> (4 * $urandom_range(0, 7));
        dp_in   = 8'($urandom);
        load    = 1'b1;
      end
      step();
    end
    rst = 1'b1;
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
